medidor_periodo: RTL and testbench
==================================

# medidor_periodo

Measures the high time, low time and period of a slow, asynchronous square-wave input in `clock_in` cycles, and publishes one result per full input period. It closes the loop on `Divisor_Frequencia`: its output, or any external pulse train, is fed back here, so divided clocks can be checked in hardware and shown on the board's displays through the MIPS I/O path. All logic is in the `clock_in` domain.

## Interface
- `WIDTH`, default 28: width of the high and low counters; matches the divider counter width.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `signal_in`; minimum 2.

- `clock_in`  in  1  system clock (50 MHz board clock).
- `reset_n`  in  1  reset; synchronous, active-low.
- `signal_in`  in  1  asynchronous signal under measurement.
- `enable`  in  1  arms the measurement; low forces IDLE.
- `high_count`  out  WIDTH  high time of the last complete period, in cycles.
- `low_count`  out  WIDTH  low time of the last complete period, in cycles.
- `period`  out  WIDTH+1  `high_count + low_count`, computed at full width with no truncation.
- `valid`  out  1  one-cycle pulse when all three result outputs update.
- `overflow`  out  1  qualifies the current result; 1 if either counter saturated during that period.
- `no_signal`  out  1  sticky; set when a running counter reaches saturation, cleared on the next `valid`.

## Operation
- `signal_in` passes through `SYNC_STAGES` flops, then one delay flop. This gives the synchronized level `s`, plus `rise = s & ~s_d` and `fall = ~s & s_d`.
- FSM states: IDLE, WAIT_RISE, HIGH, LOW.
  - IDLE: if `enable` is high, go to WAIT_RISE.
  - WAIT_RISE: the first partial period is discarded. On `rise`, set hc = 1 and go to HIGH.
  - HIGH:
    - Each cycle with `s` high, hc increments.
    - On `fall`, latch hc into a hold register, set lc = 1 and go to LOW.
  - LOW:
    - Each cycle with `s` low, lc increments.
    - On `rise`, load `high_count` = hold and `low_count` = lc, compute `period`, and pulse `valid`.
    - On the same `rise`, set hc = 1 and go to HIGH. Measurement continues back-to-back with no lost period.
  - `enable` low in any state: go to IDLE next cycle. Results hold their last values, no `valid` pulse, counters are cleared.
- Saturation:
  - hc and lc stop at 2^WIDTH−1 and do not wrap.
  - Reaching saturation sets `no_signal` and an internal ovf bit.
  - At the next `valid`, `overflow` = ovf, and ovf is cleared.
  - While saturated, the FSM stays in its state, waiting for the edge.
- The synchronizer and edge detector keep running in IDLE. As a result, a level already high at arming is not treated as a rise.

## Timing
- Reset (`reset_n` = 0 at a `clock_in` edge):
  - State becomes IDLE.
  - `high_count`, `low_count`, `period`, `valid`, `overflow`, `no_signal` and all counters go to 0.
  - Synchronizer flops go to 0.
  - Reset mid-measurement aborts it with no `valid`.
- Edge latency: `rise`/`fall` appear `SYNC_STAGES` cycles after a raw `signal_in` transition is sampled.
- `valid` is registered and is high for exactly one cycle. It is visible `SYNC_STAGES`+1 clock edges after the raw rising edge that closes the period. All result outputs change in the same cycle as `valid` and are stable until the next `valid`.
- First `valid` after arming: the second detected rise after WAIT_RISE is entered.
- Minimum measurable phase is 1 cycle: high = 1 and low = 1 gives `period` = 2. This is `Divisor_Frequencia` with DIVISOR = 2.
- If `rise` coincides with `enable` falling, IDLE wins and no `valid` is produced.

## Structure
- Shared package `medidor_pkg` holds:
  - the state encodings (IDLE = 0, WAIT_RISE = 1, HIGH = 2, LOW = 3);
  - the default `WIDTH`;
  - a saturation constant derived from `WIDTH`.
- Sub-module `sincronizador_borda`: the parameterized `SYNC_STAGES` synchronizer plus delay flop. It outputs `s`, `rise` and `fall`, resets to 0 on `reset_n`, and is reusable for the button inputs.
- The top level contains the FSM, the two saturating counters, the hold register and the output registers.

## Test plan
- Drive `signal_in` from `Divisor_Frequencia` with DIVISOR = 2 and `enable` = 1. Every valid result must be high = 1, low = 1, period = 2, `overflow` = 0, with a `valid` every 2 cycles after the first.
- Drive 7 cycles high and 3 cycles low, repeated. Results must be high = 7, low = 3, period = 10, and the first `valid` must occur on the second rise after arming.
- With `WIDTH` = 4, hold `signal_in` high for 20 cycles, then toggle. Expected: `no_signal` = 1 after hc reaches 15; the next `valid` reports high = 15 with `overflow` = 1; `no_signal` clears on that `valid`; the following period reports `overflow` = 0.
- Drop `enable` mid-HIGH, then re-raise it. Expected: no `valid` during the gap, outputs hold their old values, and the WAIT_RISE discard is repeated.
- Assert `reset_n` = 0 for one cycle during LOW. All outputs must be 0 on the next cycle, with no `valid` until a full new period plus the WAIT_RISE discard.
- Toggle `signal_in` asynchronously to `clock_in` (non-integer phase) with a 50-cycle period. Each `period` must be 50 ±1 and `high_count + low_count` must equal `period` every time.

Source files
------------

// File: rtl/medidor_periodo_pkg.sv
// Shared types and constants for the period meter: FSM state encoding,
// default counter width and the saturation value the counters stop at.
package medidor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } estado_t;

  localparam int WIDTH_DEFAULT = 28;

  // All-ones value for a counter of the given width.
  function automatic logic [63:0] saturacao(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  localparam logic [WIDTH_DEFAULT-1:0] SAT_DEFAULT = WIDTH_DEFAULT'(saturacao(WIDTH_DEFAULT));

endpackage

// File: rtl/medidor_periodo_if.sv
// Bundles the measured input, arm control and result outputs of the period meter.
interface medidor_periodo_if
  import medidor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             signal_in;
  logic             enable;
  logic [WIDTH-1:0] high_count;
  logic [WIDTH-1:0] low_count;
  logic [WIDTH:0]   period;
  logic             valid;
  logic             overflow;
  logic             no_signal;

  modport master (
    output signal_in, enable,
    input  high_count, low_count, period, valid, overflow, no_signal
  );

  modport slave (
    input  signal_in, enable,
    output high_count, low_count, period, valid, overflow, no_signal
  );

endinterface

// File: rtl/medidor_periodo_sincronizador_borda.sv
// Multi-flop synchronizer for an asynchronous input followed by a delay flop,
// giving the synchronized level and single-cycle rise/fall strobes.
module sincronizador_borda #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~delay_q;
  assign fall_o = ~s_o & delay_q;

endmodule

// File: rtl/medidor_periodo.sv
// Period meter: counts high and low time of a slow asynchronous square wave
// and publishes high, low and period once per complete input period.
module medidor_periodo
  import medidor_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input logic               clock_in,
  input logic               reset_n,
  medidor_periodo_if.slave  bus
);

  localparam logic [WIDTH-1:0] SAT    = WIDTH'(saturacao(WIDTH));
  localparam logic [WIDTH-1:0] SAT_M1 = SAT - 1'b1;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic s, rise, fall;

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] hc_q, hc_d;
  logic [WIDTH-1:0] lc_q, lc_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             no_signal_q, no_signal_d;
  logic             sat_hit;

  sincronizador_borda #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .async_i  (bus.signal_in),
    .s_o      (s),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hc_q        <= '0;
      lc_q        <= '0;
      hold_q      <= '0;
      ovf_q       <= 1'b0;
      high_q      <= '0;
      low_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      no_signal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      lc_q        <= lc_d;
      hold_q      <= hold_d;
      ovf_q       <= ovf_d;
      high_q      <= high_d;
      low_q       <= low_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      no_signal_q <= no_signal_d;
    end
  end

  // Disarming beats everything, including a rise that would close a period.
  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    lc_d        = lc_q;
    hold_d      = hold_q;
    ovf_d       = ovf_q;
    high_d      = high_q;
    low_d       = low_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q;
    no_signal_d = no_signal_q;
    sat_hit     = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
      hc_d    = '0;
      lc_d    = '0;
      hold_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            hc_d    = ONE;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hold_d  = hc_q;
            lc_d    = ONE;
            state_d = LOW;
          end else if (s && hc_q != SAT) begin
            hc_d    = hc_q + 1'b1;
            sat_hit = (hc_q == SAT_M1);
          end
        end
        LOW: begin
          if (rise) begin
            high_d     = hold_q;
            low_d      = lc_q;
            period_d   = {1'b0, hold_q} + {1'b0, lc_q};
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            ovf_d      = 1'b0;
            hc_d       = ONE;
            state_d    = HIGH;
          end else if (!s && lc_q != SAT) begin
            lc_d    = lc_q + 1'b1;
            sat_hit = (lc_q == SAT_M1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (valid_d) begin
      no_signal_d = 1'b0;
    end else if (sat_hit) begin
      no_signal_d = 1'b1;
      ovf_d       = 1'b1;
    end
  end

  assign bus.high_count = high_q;
  assign bus.low_count  = low_q;
  assign bus.period     = period_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.no_signal  = no_signal_q;

endmodule

// File: tb/tb_medidor_periodo.sv
// Directed bench for medidor_periodo: a 28-bit instance for the main scenarios
// and a 4-bit instance to reach counter saturation quickly.
module tb_medidor_periodo;

  logic clock_in = 1'b0;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  logic [28:0] got  [6];
  logic [28:0] expv [6];
  string       nm   [6] = '{"valid", "high_count", "low_count", "period", "overflow", "no_signal"};

  medidor_periodo_if #(.WIDTH(28)) bus  ();
  medidor_periodo_if #(.WIDTH(4))  bus4 ();

  medidor_periodo #(.WIDTH(28), .SYNC_STAGES(2)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  medidor_periodo #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .bus      (bus4)
  );

  always #5 clock_in = ~clock_in;

  task automatic sample_main();
    got[0] = 29'(bus.valid);
    got[1] = 29'(bus.high_count);
    got[2] = 29'(bus.low_count);
    got[3] = bus.period;
    got[4] = 29'(bus.overflow);
    got[5] = 29'(bus.no_signal);
  endtask

  task automatic sample_small();
    got[0] = 29'(bus4.valid);
    got[1] = 29'(bus4.high_count);
    got[2] = 29'(bus4.low_count);
    got[3] = 29'(bus4.period);
    got[4] = 29'(bus4.overflow);
    got[5] = 29'(bus4.no_signal);
  endtask

  task automatic set_expected(input int v, input int h, input int l, input int p,
                              input int o, input int n);
    expv[0] = 29'(v);
    expv[1] = 29'(h);
    expv[2] = 29'(l);
    expv[3] = 29'(p);
    expv[4] = 29'(o);
    expv[5] = 29'(n);
  endtask

  // Both instances disarmed with a quiet input, long enough to flush the synchronizers.
  task automatic idle_gap();
    bus.enable      = 1'b0;
    bus.signal_in   = 1'b0;
    bus4.enable     = 1'b0;
    bus4.signal_in  = 1'b0;
    repeat (6) @(negedge clock_in);
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.enable     = 1'b0;
    bus.signal_in  = 1'b0;
    bus4.enable    = 1'b0;
    bus4.signal_in = 1'b0;
    repeat (3) @(negedge clock_in);
    sample_main();
    set_expected(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[k] !== expv[k]) begin
        errors++;
        $display("[TB] FAIL reset %s: got %0d expected %0d", nm[k], got[k], expv[k]);
      end
    end
    reset_n = 1'b1;
    @(negedge clock_in);
  endtask

  task automatic test_divisor2();
    bus.enable    = 1'b1;
    bus.signal_in = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock_in);
      sample_main();
      if (j >= 8) set_expected((j % 2 == 0) ? 1 : 0, 1, 1, 2, 0, 0);
      else        set_expected(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[k] !== expv[k]) begin
          errors++;
          $display("[TB] FAIL divisor2 %s step %0d: got %0d expected %0d", nm[k], j, got[k], expv[k]);
        end
      end
      bus.signal_in = (j >= 3) && ((j - 3) % 2 == 0);
    end
  endtask

  task automatic test_pattern_7_3();
    bus.enable    = 1'b1;
    bus.signal_in = 1'b0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clock_in);
      sample_main();
      if (j < 16) set_expected(0, 1, 1, 2, 0, 0);
      else        set_expected((j == 16 || j == 26 || j == 36 || j == 46) ? 1 : 0, 7, 3, 10, 0, 0);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[k] !== expv[k]) begin
          errors++;
          $display("[TB] FAIL pattern_7_3 %s step %0d: got %0d expected %0d", nm[k], j, got[k], expv[k]);
        end
      end
      bus.signal_in = (j >= 3) && (((j - 3) % 10) < 7);
    end
  endtask

  // 5 high / 4 low; disarm mid-HIGH, re-arm, then disarm on the cycle a rise closes a period.
  task automatic test_enable_drop();
    bus.enable    = 1'b1;
    bus.signal_in = 1'b0;
    for (int j = 0; j < 75; j++) begin
      @(negedge clock_in);
      sample_main();
      if (j < 15) set_expected(0, 7, 3, 10, 0, 0);
      else        set_expected((j == 15 || j == 24 || j == 51 || j == 60) ? 1 : 0, 5, 4, 9, 0, 0);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[k] !== expv[k]) begin
          errors++;
          $display("[TB] FAIL enable_drop %s step %0d: got %0d expected %0d", nm[k], j, got[k], expv[k]);
        end
      end
      bus.signal_in = (j >= 3) && (((j - 3) % 9) < 5);
      bus.enable    = !(j >= 25 && j <= 35) && (j < 68);
    end
  endtask

  // 6 high / 6 low; one reset cycle lands while the FSM is in LOW.
  task automatic test_reset_mid();
    bus.enable    = 1'b1;
    bus.signal_in = 1'b0;
    for (int j = 0; j < 70; j++) begin
      @(negedge clock_in);
      sample_main();
      if (j < 18)      set_expected(0, 5, 4, 9, 0, 0);
      else if (j < 37) set_expected((j == 18 || j == 30) ? 1 : 0, 6, 6, 12, 0, 0);
      else if (j < 54) set_expected(0, 0, 0, 0, 0, 0);
      else             set_expected((j == 54 || j == 66) ? 1 : 0, 6, 6, 12, 0, 0);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[k] !== expv[k]) begin
          errors++;
          $display("[TB] FAIL reset_mid %s step %0d: got %0d expected %0d", nm[k], j, got[k], expv[k]);
        end
      end
      bus.signal_in = (j >= 3) && (((j - 3) % 12) < 6);
      reset_n       = (j == 36) ? 1'b0 : 1'b1;
    end
    reset_n = 1'b1;
  endtask

  // 4-bit instance: 20 cycles high saturates hc at 15, then 2 high / 3 low.
  task automatic test_saturation();
    bus4.enable    = 1'b1;
    bus4.signal_in = 1'b0;
    for (int j = 0; j < 42; j++) begin
      @(negedge clock_in);
      sample_small();
      if (j < 20)      set_expected(0, 0, 0, 0, 0, 0);
      else if (j < 29) set_expected(0, 0, 0, 0, 0, 1);
      else if (j < 34) set_expected((j == 29) ? 1 : 0, 15, 3, 18, 1, 0);
      else             set_expected((j == 34 || j == 39) ? 1 : 0, 2, 3, 5, 0, 0);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[k] !== expv[k]) begin
          errors++;
          $display("[TB] FAIL saturation %s step %0d: got %0d expected %0d", nm[k], j, got[k], expv[k]);
        end
      end
      if (j < 3)       bus4.signal_in = 1'b0;
      else if (j < 23) bus4.signal_in = 1'b1;
      else if (j < 26) bus4.signal_in = 1'b0;
      else             bus4.signal_in = (((j - 26) % 5) < 2);
    end
  endtask

  // 501-unit period against a 10-unit clock, so the input phase drifts each period.
  task automatic test_async();
    int          nvalid;
    logic [28:0] soma;
    nvalid        = 0;
    bus.enable    = 1'b1;
    bus.signal_in = 1'b0;
    fork
      begin
        #6;
        repeat (8) begin
          bus.signal_in = 1'b1;
          #250;
          bus.signal_in = 1'b0;
          #251;
        end
      end
      begin
        for (int j = 0; j < 420; j++) begin
          @(negedge clock_in);
          if (bus.valid === 1'b1) begin
            nvalid++;
            soma = {1'b0, bus.high_count} + {1'b0, bus.low_count};
            checks++;
            if (bus.period < 29'd49 || bus.period > 29'd51) begin
              errors++;
              $display("[TB] FAIL async period step %0d: got %0d expected 49..51", j, bus.period);
            end
            checks++;
            if (soma !== bus.period) begin
              errors++;
              $display("[TB] FAIL async sum step %0d: got high+low %0d expected period %0d", j, soma, bus.period);
            end
            checks++;
            if (bus.overflow !== 1'b0) begin
              errors++;
              $display("[TB] FAIL async overflow step %0d: got %0d expected 0", j, bus.overflow);
            end
          end
        end
      end
    join
    checks++;
    if (nvalid != 7) begin
      errors++;
      $display("[TB] FAIL async valid_count: got %0d expected 7", nvalid);
    end
  endtask

  initial begin
    test_reset();
    test_divisor2();
    idle_gap();
    test_pattern_7_3();
    idle_gap();
    test_enable_drop();
    idle_gap();
    test_reset_mid();
    idle_gap();
    test_saturation();
    idle_gap();
    test_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
